rank_sorter: RTL and testbench
==============================

# rank_sorter

Sorted holding buffer that acts as the reader for the rank pipeline's output interface: it pulls `(rank, meta)` pairs out with a valid/remove handshake and keeps them ordered by ascending rank. It presents the lowest-rank entry to the downstream scheduler for dequeue. It sits between the rank pipeline and the output arbitration logic, and forms a small PIFO.

## Interface
Parameters:
- `RANK_WIDTH`, 16: rank field width; must match the rank pipeline.
- `META_WIDTH`, 16: metadata width; must match the rank pipeline.
- `L2_DEPTH`, 3: log2 of the number of entries (default 8 slots).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `up_valid`  in  1  upstream holds a ranked entry.
- `up_rank`  in  RANK_WIDTH  rank of upstream entry.
- `up_meta`  in  META_WIDTH  metadata of upstream entry.
- `up_remove`  out  1  combinational; consumes the upstream entry this cycle.
- `deq`  in  1  pop the head; legal only while `deq_valid`=1.
- `deq_valid`  out  1  buffer non-empty.
- `deq_rank`  out  RANK_WIDTH  rank of head (lowest).
- `deq_meta`  out  META_WIDTH  metadata of head.
- `count`  out  L2_DEPTH+1  occupancy, range 0..2^L2_DEPTH.
- `full`  out  1  `count` == 2^L2_DEPTH.
- `drop`  out  1  present only with `RANK_SORTER_DROP_EN`; one-cycle pulse per discarded entry.

## Operation
- Storage is slots 0..N-1, with N = 2^L2_DEPTH, each holding a valid bit, rank and meta. Slot 0 is the head. Valid slots are contiguous from 0 and sorted so that rank is non-decreasing.
- Accept condition, without the macro: `up_remove` = `up_valid` & (~`full` | `deq`).
- Insert position p = number of valid entries with rank <= `up_rank`. This makes ties FIFO: a new entry goes behind existing equal ranks. Slots >= p shift up one; the entry is written at p.
- Dequeue: all slots shift down one and the top slot is cleared.
- Simultaneous insert and dequeue: the shift-down and the insert are merged in the same cycle. Position is computed over slots 1..count-1, so the entry lands at p-1 (clamped at 0). `count` is unchanged.
- A `deq` while `deq_valid`=0 is ignored, with no state change. Verification flags it as a protocol error.
- Rank comparison is unsigned over the full RANK_WIDTH, with no wrap-around handling. Wrapping ranks is the upstream's responsibility.
- Reset, including in the middle of an operation: all valid bits, ranks and meta go to 0. `count`=0, `deq_valid`=0, `deq_rank`=0, `deq_meta`=0, `full`=0, `drop`=0. `up_remove` is forced to 0 while `rst`=0.

## Timing
- `up_remove` depends combinationally on `up_valid`, `full` and `deq`. It has no combinational path from `up_rank` or `up_meta`.
- Insert to visible: an entry accepted in cycle t is in the array and reflected in `count` in cycle t+1. If it is the new minimum, it appears on `deq_*` in cycle t+1.
- `deq_valid`, `deq_rank`, `deq_meta`, `count` and `full` are all registered outputs, driven directly from slot 0 and the occupancy counter.
- Throughput: one insert and one dequeue per cycle, sustained indefinitely.

## Configuration
- `RANK_SORTER_DROP_EN` defined:
  - `up_remove` = `up_valid` whenever out of reset; the block never back-pressures.
  - If the buffer is full with no `deq` and `up_rank` >= the rank of slot N-1, the incoming entry is discarded.
  - Otherwise, on a full buffer, slot N-1 is evicted and the new entry is inserted.
  - Either discard case pulses `drop` in cycle t+1.
- `RANK_SORTER_DROP_EN` undefined: back-pressure as specified under Operation, and the `drop` port is absent.

## Structure
- Shared package `pifo_pkg` holds:
  - default `RANK_WIDTH`/`META_WIDTH` constants;
  - the entry struct type {valid, rank, meta};
  - the slot-count helper function.
- Sub-module `rank_sorter_cell`, one instance per slot. Inputs: its own entry, its lower and upper neighbours, the incoming entry, and shift/insert controls. It outputs its compare result (own rank <= `up_rank`) and registers its next entry.
- The top level computes p from the cell compare vector (a thermometer code), drives the controls, and maintains `count`.

## Test plan
- Reset then insert ranks 5, 2, 9, 2 with metas A, B, C, D -> dequeue order (2,B),(2,D),(5,A),(9,C); `count` goes 1,2,3,4 then back to 0.
- Fill 8 entries with ranks 8..1, hold `up_valid` with rank 0 -> `up_remove`=0 and `full`=1. Assert `deq` -> same cycle `up_remove`=1; the next head is rank 0 and `count` stays 8.
- Continuous stream, one insert plus one deq per cycle for 100 cycles with random ranks -> `count` constant, and each dequeued rank is the minimum of the model contents.
- `deq` while empty -> no state change: `deq_valid`=0, `count`=0.
- Assert `rst`=0 with 5 entries held -> next cycle `count`=0, `deq_valid`=0, `deq_rank`=0. The first post-reset insert of rank 7 is at the head one cycle later.
- With `RANK_SORTER_DROP_EN` defined and the buffer full of ranks 1..8:
  - insert rank 9 -> `drop` pulses and the contents are unchanged;
  - insert rank 3 -> `drop` pulses, rank 8 is evicted, and 3 sits behind the existing 3.

Source files
------------

// File: rtl/pifo_pkg.sv
// -----------------------------------------------------------------------------
// pifo_pkg
// Shared definitions for the rank pipeline output side and the rank_sorter PIFO.
//   RANK_WIDTH_DEF / META_WIDTH_DEF : default field widths, shared with the
//                                     rank pipeline.
//   entry_t                         : {valid, rank, meta} at the default widths.
//                                     Instances built with other widths keep the
//                                     same field order in a flat vector.
//   cell_op_e                       : per-slot update command.
//   num_slots()                     : slot count from log2 depth.
// -----------------------------------------------------------------------------
package pifo_pkg;

  localparam int RANK_WIDTH_DEF = 16;
  localparam int META_WIDTH_DEF = 16;

  typedef struct packed {
    logic                      valid;
    logic [RANK_WIDTH_DEF-1:0] rank;
    logic [META_WIDTH_DEF-1:0] meta;
  } entry_t;

  // HOLD keeps the slot, LOAD takes the incoming entry, SHIFT_UP takes the
  // lower neighbour (make room for an insert), SHIFT_DN takes the upper
  // neighbour (close the gap left by a dequeue).
  typedef enum logic [1:0] {
    CELL_HOLD     = 2'd0,
    CELL_LOAD     = 2'd1,
    CELL_SHIFT_UP = 2'd2,
    CELL_SHIFT_DN = 2'd3
  } cell_op_e;

  function automatic int num_slots(input int l2_depth);
    return 1 << l2_depth;
  endfunction

endpackage

// File: rtl/rank_sorter_cell.sv
// -----------------------------------------------------------------------------
// rank_sorter_cell
// One storage slot of the sorted buffer. Entries travel as flat vectors laid
// out {valid, rank, meta}.
//   clk_i, rst_ni : clock, synchronous active-low reset (clears the slot)
//   op_i          : update command for this cycle
//   lower_i       : entry of slot i-1 (zero for slot 0)
//   upper_i       : entry of slot i+1 (zero for the top slot)
//   in_i          : incoming entry
//   up_rank_i     : incoming rank, used for the compare
//   le_o          : slot is valid and its rank <= up_rank_i
//   entry_o       : registered slot contents
// -----------------------------------------------------------------------------
module rank_sorter_cell
  import pifo_pkg::*;
#(
  parameter int RANK_WIDTH = RANK_WIDTH_DEF,
  parameter int META_WIDTH = META_WIDTH_DEF
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  cell_op_e                         op_i,
  input  logic [RANK_WIDTH+META_WIDTH:0]   lower_i,
  input  logic [RANK_WIDTH+META_WIDTH:0]   upper_i,
  input  logic [RANK_WIDTH+META_WIDTH:0]   in_i,
  input  logic [RANK_WIDTH-1:0]            up_rank_i,
  output logic                             le_o,
  output logic [RANK_WIDTH+META_WIDTH:0]   entry_o
);

  localparam int EW = 1 + RANK_WIDTH + META_WIDTH;

  logic [EW-1:0]         entry_q;
  logic [EW-1:0]         entry_d;
  logic                  valid;
  logic [RANK_WIDTH-1:0] rank;

  assign valid = entry_q[EW-1];
  assign rank  = entry_q[EW-2:META_WIDTH];

  // Invalid slots never count as "<=", so the compare vector across the
  // sorted array is a thermometer code starting at slot 0.
  assign le_o    = valid && (rank <= up_rank_i);
  assign entry_o = entry_q;

  always_comb begin
    entry_d = entry_q;
    case (op_i)
      CELL_LOAD:     entry_d = in_i;
      CELL_SHIFT_UP: entry_d = lower_i;
      CELL_SHIFT_DN: entry_d = upper_i;
      default:       entry_d = entry_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/rank_sorter.sv
// -----------------------------------------------------------------------------
// rank_sorter
// Small PIFO: pulls (rank, meta) pairs from the rank pipeline and keeps them
// sorted by ascending rank (FIFO among equal ranks); slot 0 is the head.
//   clk, rst               : clock, synchronous active-low reset
//   up_valid/rank/meta     : upstream entry offered
//   up_remove              : entry consumed this cycle (combinational)
//   deq                    : pop the head (ignored while deq_valid=0)
//   deq_valid/rank/meta    : registered head of the buffer
//   count, full            : occupancy, registered
//   drop                   : only with RANK_SORTER_DROP_EN; one-cycle pulse per
//                            entry discarded (incoming or evicted)
// Build option RANK_SORTER_DROP_EN: never back-pressure; on a full buffer the
// largest entry (incoming or slot N-1) is discarded.
// -----------------------------------------------------------------------------
module rank_sorter
  import pifo_pkg::*;
#(
  parameter int RANK_WIDTH = RANK_WIDTH_DEF,
  parameter int META_WIDTH = META_WIDTH_DEF,
  parameter int L2_DEPTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_valid,
  input  logic [RANK_WIDTH-1:0] up_rank,
  input  logic [META_WIDTH-1:0] up_meta,
  output logic                  up_remove,
  input  logic                  deq,
  output logic                  deq_valid,
  output logic [RANK_WIDTH-1:0] deq_rank,
  output logic [META_WIDTH-1:0] deq_meta,
  output logic [L2_DEPTH:0]     count,
  output logic                  full
`ifdef RANK_SORTER_DROP_EN
  ,
  output logic                  drop
`endif
);

  localparam int            N     = num_slots(L2_DEPTH);
  localparam int            EW    = 1 + RANK_WIDTH + META_WIDTH;
  localparam int            CW    = L2_DEPTH + 1;
  localparam logic [CW-1:0] N_CNT = CW'(N);

  logic [EW-1:0] slot_q [N];
  logic [EW-1:0] in_entry;
  logic [N-1:0]  le;
  cell_op_e      op [N];
  logic [CW-1:0] ins_pos;
  logic [CW-1:0] merge_pos;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          do_deq;
  logic          do_ins;

  assign in_entry = {1'b1, up_rank, up_meta};

  // Head and occupancy come straight from registers.
  assign deq_valid = slot_q[0][EW-1];
  assign deq_rank  = slot_q[0][EW-2:META_WIDTH];
  assign deq_meta  = slot_q[0][META_WIDTH-1:0];
  assign count     = count_q;
  assign full      = (count_q == N_CNT);

  assign do_deq = deq & deq_valid;

`ifdef RANK_SORTER_DROP_EN
  assign up_remove = rst & up_valid;
`else
  // A full buffer can still accept when the head leaves in the same cycle.
  assign up_remove = rst & up_valid & (~full | deq);
`endif
  assign do_ins = up_remove;

  // Insert position is the population count of the thermometer compare
  // vector. When a dequeue is merged in, slot 0 leaves, so only slots 1..N-1
  // count and the position is taken in the post-shift indexing.
  always_comb begin
    ins_pos   = '0;
    merge_pos = '0;
    for (int i = 0; i < N; i++) begin
      ins_pos = ins_pos + CW'(le[i]);
      if (i > 0) merge_pos = merge_pos + CW'(le[i]);
    end
  end

  // Per-slot commands. A full buffer inserting without dequeue shifts the top
  // slot out (eviction); if the position is N nothing moves (discard). Neither
  // case is reachable without the drop option because up_remove stays low.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      op[i] = CELL_HOLD;
      if (do_ins && do_deq) begin
        if (i < int'(merge_pos))       op[i] = CELL_SHIFT_DN;
        else if (i == int'(merge_pos)) op[i] = CELL_LOAD;
      end else if (do_deq) begin
        op[i] = CELL_SHIFT_DN;
      end else if (do_ins) begin
        if (i == int'(ins_pos))        op[i] = CELL_LOAD;
        else if (i > int'(ins_pos))    op[i] = CELL_SHIFT_UP;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_cell
    logic [EW-1:0] lower;
    logic [EW-1:0] upper;

    if (i == 0) begin : g_bot
      assign lower = '0;
    end else begin : g_mid_lo
      assign lower = slot_q[i-1];
    end

    if (i == N - 1) begin : g_top
      assign upper = '0;
    end else begin : g_mid_hi
      assign upper = slot_q[i+1];
    end

    rank_sorter_cell #(
      .RANK_WIDTH(RANK_WIDTH),
      .META_WIDTH(META_WIDTH)
    ) u_cell (
      .clk_i    (clk),
      .rst_ni   (rst),
      .op_i     (op[i]),
      .lower_i  (lower),
      .upper_i  (upper),
      .in_i     (in_entry),
      .up_rank_i(up_rank),
      .le_o     (le[i]),
      .entry_o  (slot_q[i])
    );
  end

  // Occupancy only moves on an unpaired insert (that actually lands in a free
  // slot) or an unpaired dequeue.
  always_comb begin
    count_d = count_q;
    if (do_ins && !do_deq && !full) begin
      count_d = count_q + CW'(1);
    end else if (!do_ins && do_deq) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

`ifdef RANK_SORTER_DROP_EN
  logic drop_q;
  logic drop_d;

  // Accepting into a full buffer without a dequeue always loses one entry.
  assign drop_d = do_ins & full & ~do_deq;
  assign drop   = drop_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end
`endif

endmodule

// File: tb/tb_rank_sorter.sv
// -----------------------------------------------------------------------------
// tb_rank_sorter
// Bench for rank_sorter (default 16/16-bit fields, 8 slots). Reference model is
// an arrival-ordered queue: the head is the lowest rank with earliest arrival,
// the eviction victim is the highest rank with latest arrival.
// -----------------------------------------------------------------------------
module tb_rank_sorter;
  import pifo_pkg::*;

  localparam int RW = 16;
  localparam int MW = 16;
  localparam int L2 = 3;
  localparam int N  = 8;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          up_valid = 1'b0;
  logic [RW-1:0] up_rank = '0;
  logic [MW-1:0] up_meta = '0;
  logic          up_remove;
  logic          deq = 1'b0;
  logic          deq_valid;
  logic [RW-1:0] deq_rank;
  logic [MW-1:0] deq_meta;
  logic [L2:0]   count;
  logic          full;
`ifdef RANK_SORTER_DROP_EN
  logic          drop;
  logic          exp_drop = 1'b0;
`endif

  always #5 clk = ~clk;

  rank_sorter #(
    .RANK_WIDTH(RW),
    .META_WIDTH(MW),
    .L2_DEPTH  (L2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .up_valid (up_valid),
    .up_rank  (up_rank),
    .up_meta  (up_meta),
    .up_remove(up_remove),
    .deq      (deq),
    .deq_valid(deq_valid),
    .deq_rank (deq_rank),
    .deq_meta (deq_meta),
    .count    (count),
    .full     (full)
`ifdef RANK_SORTER_DROP_EN
    ,
    .drop     (drop)
`endif
  );

  // ---------------- scoreboard state ----------------
  int               checks = 0;
  int               errors = 0;
  logic [RW+MW-1:0] exp_q[$];
  logic [RW+MW-1:0] mon_exp;
  entry_t           model[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int head_idx();
    int b = 0;
    for (int i = 1; i < model.size(); i++)
      if (model[i].rank < model[b].rank) b = i;
    return b;
  endfunction

  function automatic int tail_idx();
    int b = 0;
    for (int i = 1; i < model.size(); i++)
      if (model[i].rank >= model[b].rank) b = i;
    return b;
  endfunction

  task automatic check_state();
    check("count", 32'(count), 32'(model.size()));
    check("full", 32'(full), 32'(model.size() == N));
    check("deq_valid", 32'(deq_valid), 32'(model.size() != 0));
`ifdef RANK_SORTER_DROP_EN
    check("drop", 32'(drop), 32'(exp_drop));
`endif
  endtask

  // ---------------- driver ----------------
  // One clock cycle: check registered state, apply inputs, check up_remove,
  // then advance the model by what this cycle does.
  task automatic step(input int v, input int r, input int m, input int d);
    logic   exp_rm;
    entry_t e;
    int     h;
    @(posedge clk);
    #1;
    check_state();
    up_valid = (v != 0);
    up_rank  = RW'(r);
    up_meta  = MW'(m);
    deq      = (d != 0);
`ifdef RANK_SORTER_DROP_EN
    exp_rm = (v != 0);
    exp_drop = 1'b0;
`else
    exp_rm = (v != 0) && (model.size() < N || d != 0);
`endif
    #1;
    check("up_remove", 32'(up_remove), 32'(exp_rm));
    if (d != 0 && model.size() > 0) begin
      h = head_idx();
      exp_q.push_back({model[h].rank, model[h].meta});
      model.delete(h);
    end
    if (exp_rm) begin
      e = '{valid: 1'b1, rank: RW'(r), meta: MW'(m)};
      if (model.size() < N) model.push_back(e);
`ifdef RANK_SORTER_DROP_EN
      else begin
        h = tail_idx();
        exp_drop = 1'b1;
        if (RW'(r) < model[h].rank) begin
          model.delete(h);
          model.push_back(e);
        end
      end
`endif
    end
  endtask

  task automatic reset_mid(input int v);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    up_valid = (v != 0);
    up_rank  = RW'(7);
    deq      = 1'b0;
    #1;
    check("up_remove_in_reset", 32'(up_remove), 32'(0));
    @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'(0));
    check("rst_deq_valid", 32'(deq_valid), 32'(0));
    check("rst_deq_rank", 32'(deq_rank), 32'(0));
    check("rst_deq_meta", 32'(deq_meta), 32'(0));
    check("rst_full", 32'(full), 32'(0));
`ifdef RANK_SORTER_DROP_EN
    check("rst_drop", 32'(drop), 32'(0));
    exp_drop = 1'b0;
`endif
    rst      = 1'b1;
    up_valid = 1'b0;
    model.delete();
  endtask

  task automatic drain();
    while (model.size() > 0) step(0, 0, 0, 1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst && deq && deq_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deq_unexpected actual=%0h/%0h expected=none", deq_rank, deq_meta);
      end else begin
        mon_exp = exp_q.pop_front();
        check("deq_head", {deq_rank, deq_meta}, mon_exp);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    reset_mid(0);

    // Tie ordering: 5A 2B 9C 2D
    step(1, 5, 'hA, 0);
    step(1, 2, 'hB, 0);
    step(1, 9, 'hC, 0);
    step(1, 2, 'hD, 0);
    repeat (4) step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Full buffer back-pressure then merged insert+dequeue
    for (int k = 8; k >= 1; k--) step(1, k, 'h100 + k, 0);
    step(1, 0, 'h55, 0);
    step(1, 0, 'h55, 1);
    step(0, 0, 0, 0);
    check("head_after_swap", 32'(deq_rank), 32'(0));
    drain();

    // Dequeue while empty
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Sustained one-in one-out
    for (int k = 0; k < 4; k++) step(1, $urandom_range(0, 15), $urandom_range(0, 65535), 0);
    for (int k = 0; k < 100; k++) begin
      r = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(0, 65535);
      step(1, r, $urandom_range(0, 65535), 1);
    end

    // Random mix including full and empty corners
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 65535);
      step($urandom_range(0, 3) != 0, r, $urandom_range(0, 65535), $urandom_range(0, 2) == 0);
    end
    drain();

    // Reset with entries held, then first insert after reset
    for (int k = 0; k < 5; k++) step(1, 10 + k, k, 0);
    reset_mid(1);
    step(1, 7, 'h77, 0);
    step(0, 0, 0, 0);
    check("post_rst_head_valid", 32'(deq_valid), 32'(1));
    check("post_rst_head_rank", 32'(deq_rank), 32'(7));
    drain();

`ifdef RANK_SORTER_DROP_EN
    // Full of 1..8: rank 9 discarded, rank 3 evicts 8 and sits behind old 3
    for (int k = 1; k <= 8; k++) step(1, k, 'h200 + k, 0);
    step(1, 9, 'h999, 0);
    step(0, 0, 0, 0);
    step(1, 3, 'h333, 0);
    step(0, 0, 0, 0);
    drain();
`endif

    step(0, 0, 0, 0);
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
